// File: rtl/decade_chain_ctrl.sv
// rtl/decade_chain_ctrl.sv - start/stop/clear sequencer for a cascade of BCD decade counters
// A prescaler turns clock cycles into count ticks; the chain halts or wraps at a latched terminal value.
module decade_chain_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   target,
    input  logic                  wrap,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic                  tc
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic [W-1:0]    tgt_q;
    logic            reload;

    logic [W-1:0]    count_inc;
    logic [W-1:0]    tgt_clamped;
    logic            inc_carry;
    logic            tick;
    logic            step_en;

    // Ripple BCD increment: a digit advances only while every lower digit sits at 9.
    always_comb begin
        count_inc = count;
        inc_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (count[4*i +: 4] >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    inc_carry           = 1'b0;
                end
            end
        end
    end

    always_comb begin
        tgt_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            tgt_clamped[4*i +: 4] = (target[4*i +: 4] > 4'd9) ? 4'd9 : target[4*i +: 4];
        end
    end

    // A resume edge is itself a counting cycle, so a paused prescaler picks up where it left off.
    assign tick    = (prescaler == PS_LAST);
    assign step_en = ((state == RUN) && !stop) || ((state == PAUSE) && start);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            prescaler <= '0;
            tgt_q     <= '0;
            reload    <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            tc        <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                count     <= '0;
                prescaler <= '0;
                reload    <= 1'b0;
                running   <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= RUN;
                            running   <= 1'b1;
                            count     <= '0;
                            prescaler <= '0;
                            reload    <= 1'b0;
                            tgt_q     <= tgt_clamped;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase

                if (step_en) begin
                    if (tick) begin
                        prescaler <= '0;
                        if (reload) begin
                            // Tick after a wrapping match restarts the chain from zero.
                            count  <= '0;
                            reload <= 1'b0;
                        end else begin
                            count <= count_inc;
                            if (count_inc == tgt_q) begin
                                tc <= 1'b1;
                                if (!wrap) begin
                                    state   <= DONE;
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                end else begin
                                    reload <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
            end
        end
    end

endmodule
